// File: rtl/rng_pkg.sv
// Shared constants and state encoding for the LFSR random number service.
package rng_pkg;

    localparam int unsigned RNG_W = 8;
    localparam logic [RNG_W-1:0] RNG_SEED = 8'h69;

    localparam int unsigned MIX_STEPS_DEF = 8;
    localparam int unsigned MAX_RETRY_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MIX   = 2'd1,
        CHECK = 2'd2,
        GRANT = 2'd3
    } state_e;

endpackage

// File: rtl/rng.sv
// 8-bit XNOR-feedback LFSR; steps once per cycle while switch is high.
module rng
    import rng_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             switch,
    output logic [RNG_W-1:0] out
);

    logic [RNG_W-1:0] out_q, out_d;

    always_comb begin
        out_d = out_q;
        if (switch) begin
            out_d = {out_q[6:0], ~(out_q[2] ^ out_q[3] ^ out_q[4] ^ out_q[6])};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= RNG_SEED;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one LFSR among N_REQ requesters, returning a value
// in 0..bound[id] via rejection sampling with a bounded retry count.
module rng_arbiter
    import rng_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned MIX_STEPS = MIX_STEPS_DEF,
    parameter int unsigned MAX_RETRY = MAX_RETRY_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   free_run,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*RNG_W-1:0] bound,
    output logic [N_REQ-1:0]       ack,
    output logic [RNG_W-1:0]       rnd,
    output logic                   busy
);

    localparam int unsigned IdW    = $clog2(N_REQ);
    localparam int unsigned CntW   = (MIX_STEPS > 1) ? $clog2(MIX_STEPS) : 1;
    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CntW-1:0]   CntLoad  = CntW'(MIX_STEPS - 1);
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

    state_e              state_q, state_d;
    logic [IdW-1:0]      ptr_q, ptr_d;
    logic [IdW-1:0]      id_q, id_d;
    logic [RNG_W-1:0]    b_lat_q, b_lat_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [RetryW-1:0]   retry_q, retry_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic [RNG_W-1:0]    rnd_q, rnd_d;
    logic                busy_q, busy_d;

    logic                rng_switch;
    logic [RNG_W-1:0]    rng_out;
    logic [IdW-1:0]      pick;
    logic [IdW-1:0]      idx;
    logic                found;

    rng u_rng (
        .clk    (clk),
        .rst    (rst),
        .switch (rng_switch),
        .out    (rng_out)
    );

    always_comb begin
        unique case (state_q)
            IDLE:    rng_switch = free_run;
            MIX:     rng_switch = 1'b1;
            default: rng_switch = 1'b0;
        endcase
    end

    // First set request at or after ptr, wrapping around.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = IdW'((32'(ptr_q) + k) % N_REQ);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        b_lat_d = b_lat_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        ack_d   = '0;
        rnd_d   = rnd_q;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    id_d    = pick;
                    b_lat_d = bound[pick*RNG_W +: RNG_W];
                    cnt_d   = CntLoad;
                    retry_d = '0;
                    busy_d  = 1'b1;
                    state_d = MIX;
                end
            end
            MIX: begin
                if (cnt_q == '0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CHECK: begin
                state_d = GRANT;
                ack_d   = N_REQ'(1) << id_q;
                if (b_lat_q == '0) begin
                    rnd_d = '0;
                end else if (rng_out <= b_lat_q) begin
                    rnd_d = rng_out;
                end else if (retry_q != RetryMax) begin
                    retry_d = retry_q + 1'b1;
                    cnt_d   = CntLoad;
                    state_d = MIX;
                    ack_d   = '0;
                end else begin
                    // Biased fallback once retries are exhausted; never exceeds b_lat.
                    rnd_d = rng_out & b_lat_q;
                end
            end
            GRANT: begin
                ptr_d   = (id_q == IdW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            b_lat_q <= '0;
            cnt_q   <= '0;
            retry_q <= '0;
            ack_q   <= '0;
            rnd_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            b_lat_q <= b_lat_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            ack_q   <= ack_d;
            rnd_q   <= rnd_d;
            busy_q  <= busy_d;
        end
    end

    assign ack  = ack_q;
    assign rnd  = rnd_q;
    assign busy = busy_q;

endmodule
